// File: rtl/level_meter_multi.sv
// Multi-channel mean-square level meter: per-window power -> dBFS tenths -> shared BCD converter.
// Optional peak hold on the displayed value: define LEVEL_PEAK_HOLD_EN.
module level_meter_multi #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned CHANNELS     = 2,
    parameter int unsigned WINDOW_LOG2  = 13,
    parameter int unsigned HOLD_WINDOWS = 4
) (
    input  logic                      clk_48,
    input  logic                      reset_n,
    input  logic                      in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic                      clear,
    output logic [CHANNELS*4-1:0]     num2,
    output logic [CHANNELS*4-1:0]     num1,
    output logic [CHANNELS*4-1:0]     num0,
    output logic [CHANNELS-1:0]       neg,
    output logic                      update,
    output logic                      busy,
    output logic                      overrun
);
    localparam int unsigned SqW  = 2 * WIDTH;
    localparam int unsigned AccW = SqW + WINDOW_LOG2;
    localparam int unsigned CntW = WINDOW_LOG2 + 1;
    localparam int unsigned PosW = $clog2(SqW);
    localparam int unsigned LogW = PosW + 4;
    localparam int unsigned ChW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [CntW-1:0] CntLast  = CntW'((1 << WINDOW_LOG2) - 1);
    localparam logic [PosW-1:0] TopPos   = PosW'(SqW - 1);
    localparam logic [ChW-1:0]  ChLast   = ChW'(CHANNELS - 1);
    localparam int              FullScaleL = 32 * (int'(WIDTH) - 1);
    localparam int              FloorT   = -999;

    if (WIDTH < 8 || WIDTH > 24) begin : gen_bad_width
        $error("WIDTH must be 8..24");
    end
    if (CHANNELS < 1 || CHANNELS > 8) begin : gen_bad_channels
        $error("CHANNELS must be 1..8");
    end
    if (WINDOW_LOG2 < 6 || WINDOW_LOG2 > 16) begin : gen_bad_window
        $error("WINDOW_LOG2 must be 6..16");
    end
    if (HOLD_WINDOWS < 1) begin : gen_bad_hold
        $error("HOLD_WINDOWS must be at least 1");
    end

    typedef enum logic [2:0] {StIdle, StLog, StScale, StBcd, StDone} state_e;

    state_e          state_q, state_d;
    logic [AccW-1:0] acc_q   [CHANNELS];
    logic [AccW-1:0] acc_sum [CHANNELS];
    logic [SqW-1:0]  ms_q    [CHANNELS];
    logic [CntW-1:0] cnt_q;
    logic            win_end, take_snap;

    logic [ChW-1:0]  ch_q, ch_d;
    logic [LogW-1:0] l_q, l_d;
    logic            zero_q, zero_d;
    logic [9:0]      m_q, m_d;
    logic [3:0]      d2_q, d2_d, d1_q, d1_d;
    logic            sgn_q, sgn_d;
    logic            res_we;

    logic [3:0]          res2_q [CHANNELS];
    logic [3:0]          res1_q [CHANNELS];
    logic [3:0]          res0_q [CHANNELS];
    logic [CHANNELS-1:0] resneg_q;

    logic [SqW-1:0]  ms_cur, ms_norm;
    logic [PosW-1:0] msb_pos;
    logic [3:0]      frac;
    int              t_raw, t_lim, t_out;

    // Squares are non-negative and below 2^(2*WIDTH-1), so the low product bits are exact.
    for (genvar c = 0; c < CHANNELS; c++) begin : gen_sq
        logic [SqW-1:0] ext, sq;
        assign ext        = SqW'($signed(in_data[c*WIDTH +: WIDTH]));
        assign sq         = ext * ext;
        assign acc_sum[c] = acc_q[c] + AccW'(sq);
    end

    assign win_end   = in_valid && !clear && (cnt_q == CntLast);
    assign take_snap = win_end && (state_q == StIdle);

    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            overrun <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                acc_q[c] <= '0;
                ms_q[c]  <= '0;
            end
        end else begin
            if (clear || win_end) begin
                cnt_q <= '0;
                for (int c = 0; c < CHANNELS; c++) acc_q[c] <= '0;
            end else if (in_valid) begin
                cnt_q <= cnt_q + 1'b1;
                for (int c = 0; c < CHANNELS; c++) acc_q[c] <= acc_sum[c];
            end
            if (take_snap) begin
                for (int c = 0; c < CHANNELS; c++) ms_q[c] <= acc_sum[c][AccW-1:WINDOW_LOG2];
            end
            if (win_end && (state_q != StIdle)) overrun <= 1'b1;
        end
    end

    // Log2 estimate: MSB position plus four mantissa bits taken after normalising.
    assign ms_cur = ms_q[ch_q];

    always_comb begin
        msb_pos = '0;
        for (int i = 0; i < SqW; i++) begin
            if (ms_cur[i]) msb_pos = PosW'(i);
        end
        ms_norm = ms_cur << (TopPos - msb_pos);
        frac    = 4'(ms_norm >> (SqW - 5));
    end

    // 1927/1024 ~= 10*log10(2)*(16/... ) scaling of the 1/16-octave log to tenths of a dB.
    always_comb begin
        t_raw = ((int'(l_q) - FullScaleL) * 1927) >>> 10;
        if (zero_q || (t_raw < FloorT)) begin
            t_lim = FloorT;
        end else if (t_raw > 0) begin
            t_lim = 0;
        end else begin
            t_lim = t_raw;
        end
    end

`ifdef LEVEL_PEAK_HOLD_EN
    localparam int unsigned HoldW = $clog2(HOLD_WINDOWS + 1);

    logic signed [10:0] held_q [CHANNELS];
    logic [HoldW-1:0]   hcnt_q [CHANNELS];
    logic               hold_load;

    always_comb begin
        hold_load = (t_lim >= int'(held_q[ch_q])) || (hcnt_q[ch_q] == '0);
        t_out     = hold_load ? t_lim : int'(held_q[ch_q]);
    end

    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                held_q[c] <= 11'(FloorT);
                hcnt_q[c] <= '0;
            end
        end else if (state_q == StScale) begin
            if (hold_load) begin
                held_q[ch_q] <= 11'(t_lim);
                hcnt_q[ch_q] <= HoldW'(HOLD_WINDOWS);
            end else begin
                hcnt_q[ch_q] <= hcnt_q[ch_q] - 1'b1;
            end
        end
    end
`else
    always_comb t_out = t_lim;
`endif

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        l_d     = l_q;
        zero_d  = zero_q;
        m_d     = m_q;
        d2_d    = d2_q;
        d1_d    = d1_q;
        sgn_d   = sgn_q;
        res_we  = 1'b0;
        case (state_q)
            StIdle: begin
                if (take_snap) begin
                    state_d = StLog;
                    ch_d    = '0;
                end
            end
            StLog: begin
                l_d     = {msb_pos, frac};
                zero_d  = (ms_cur == '0);
                state_d = StScale;
            end
            StScale: begin
                sgn_d   = (t_out < 0);
                m_d     = 10'(-t_out);
                d2_d    = '0;
                d1_d    = '0;
                state_d = StBcd;
            end
            StBcd: begin
                if (m_q >= 10'd100) begin
                    m_d  = m_q - 10'd100;
                    d2_d = d2_q + 1'b1;
                end else if (m_q >= 10'd10) begin
                    m_d  = m_q - 10'd10;
                    d1_d = d1_q + 1'b1;
                end else begin
                    res_we = 1'b1;
                    if (ch_q == ChLast) begin
                        state_d = StDone;
                    end else begin
                        ch_d    = ch_q + 1'b1;
                        state_d = StLog;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            ch_q     <= '0;
            l_q      <= '0;
            zero_q   <= 1'b0;
            m_q      <= '0;
            d2_q     <= '0;
            d1_q     <= '0;
            sgn_q    <= 1'b0;
            resneg_q <= '0;
            num2     <= '0;
            num1     <= '0;
            num0     <= '0;
            neg      <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                res2_q[c] <= '0;
                res1_q[c] <= '0;
                res0_q[c] <= '0;
            end
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            l_q     <= l_d;
            zero_q  <= zero_d;
            m_q     <= m_d;
            d2_q    <= d2_d;
            d1_q    <= d1_d;
            sgn_q   <= sgn_d;
            if (res_we) begin
                res2_q[ch_q]   <= d2_q;
                res1_q[ch_q]   <= d1_q;
                res0_q[ch_q]   <= m_q[3:0];
                resneg_q[ch_q] <= sgn_q;
            end
            // All channels change together so the display never shows a mixed set.
            if (state_q == StDone) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    num2[c*4 +: 4] <= res2_q[c];
                    num1[c*4 +: 4] <= res1_q[c];
                    num0[c*4 +: 4] <= res0_q[c];
                end
                neg <= resneg_q;
            end
        end
    end

    assign update = (state_q == StDone);
    assign busy   = (state_q != StIdle);

endmodule

// File: tb/tb_level_meter_multi.sv
// Self-checking bench for level_meter_multi: randomized windows against an arithmetic dBFS model.
module tb_level_meter_multi;
    localparam int W       = 16;
    localparam int CH      = 8;
    localparam int WL      = 6;
    localparam int HOLD    = 4;
    localparam int WIN     = 1 << WL;
    localparam int MAX_LAT = 34 * CH + 2;

    logic            clk_48   = 1'b0;
    logic            reset_n  = 1'b0;
    logic            in_valid = 1'b0;
    logic            clear    = 1'b0;
    logic [CH*W-1:0] in_data  = '0;
    logic [CH*4-1:0] num2, num1, num0;
    logic [CH-1:0]   neg;
    logic            update, busy, overrun;

    level_meter_multi #(
        .WIDTH       (W),
        .CHANNELS    (CH),
        .WINDOW_LOG2 (WL),
        .HOLD_WINDOWS(HOLD)
    ) dut (
        .clk_48  (clk_48),
        .reset_n (reset_n),
        .in_valid(in_valid),
        .in_data (in_data),
        .clear   (clear),
        .num2    (num2),
        .num1    (num1),
        .num0    (num0),
        .neg     (neg),
        .update  (update),
        .busy    (busy),
        .overrun (overrun)
    );

    always #5 clk_48 = ~clk_48;

    int checks  = 0;
    int errors  = 0;
    int upd_cnt = 0;

    always @(negedge clk_48) if (update === 1'b1) upd_cnt++;

    // Reference model state
    longint              sum_m  [CH];
    int                  cnt_m;
    int                  exp_t  [CH];
    int                  held_m [CH];
    int                  hcnt_m [CH];
    bit                  discard = 1'b0;
    logic signed [W-1:0] smp    [CH];

    task automatic tick();
        @(negedge clk_48);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // dBFS tenths straight from the mean-square value with plain integer arithmetic.
    function automatic int level_tenths(input longint sum);
        longint ms;
        longint num;
        int     p, f, l, t;
        ms = sum / WIN;
        if (ms == 0) return -999;
        p = 0;
        for (int i = 0; i < 2 * W; i++) if (ms >= (longint'(1) << i)) p = i;
        if (p >= 4) f = int'((ms >> (p - 4)) % 16);
        else        f = int'((ms << (4 - p)) % 16);
        l   = 16 * p + f;
        num = longint'(l - 32 * (W - 1)) * 1927;
        if (num >= 0) t = int'(num / 1024);
        else          t = -int'((-num + 1023) / 1024);
        if (t < -999) t = -999;
        if (t > 0)    t = 0;
        return t;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            sum_m[c]  = 0;
            exp_t[c]  = 0;
            held_m[c] = -999;
            hcnt_m[c] = 0;
        end
        cnt_m = 0;
    endtask

    task automatic model_window_end();
        int t;
        for (int c = 0; c < CH; c++) begin
            if (!discard) begin
                t = level_tenths(sum_m[c]);
`ifdef LEVEL_PEAK_HOLD_EN
                if (t >= held_m[c] || hcnt_m[c] == 0) begin
                    held_m[c] = t;
                    hcnt_m[c] = HOLD;
                end else begin
                    hcnt_m[c]--;
                    t = held_m[c];
                end
`endif
                exp_t[c] = t;
            end
            sum_m[c] = 0;
        end
        cnt_m = 0;
    endtask

    task automatic push(input int gap);
        for (int c = 0; c < CH; c++) in_data[c*W +: W] = smp[c];
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < CH; c++) sum_m[c] += longint'(smp[c]) * longint'(smp[c]);
        cnt_m++;
        if (cnt_m == WIN) model_window_end();
        repeat (gap) tick();
    endtask

    // Channels below fixed_ch keep their smp value; the rest are randomized each strobe.
    task automatic run_strobes(input int n, input int fixed_ch, input int amp, input int gap);
        logic signed [W-1:0] r;
        for (int i = 0; i < n; i++) begin
            for (int c = fixed_ch; c < CH; c++) begin
                r      = W'($urandom);
                smp[c] = r >>> amp;
            end
            push((i == n - 1) ? 0 : gap);
        end
    endtask

    task automatic check_outputs(input string tag);
        int mag;
        for (int c = 0; c < CH; c++) begin
            mag = (exp_t[c] < 0) ? -exp_t[c] : exp_t[c];
            check($sformatf("%s ch%0d num2", tag, c), 64'(num2[c*4 +: 4]), 64'(mag / 100));
            check($sformatf("%s ch%0d num1", tag, c), 64'(num1[c*4 +: 4]), 64'((mag / 10) % 10));
            check($sformatf("%s ch%0d num0", tag, c), 64'(num0[c*4 +: 4]), 64'(mag % 10));
            check($sformatf("%s ch%0d neg", tag, c), 64'(neg[c]), 64'(exp_t[c] < 0));
        end
    endtask

    task automatic finish_window(input string tag, input int u0, input bit check_lat);
        int lat;
        lat = 0;
        while (update !== 1'b1 && lat < 2 * MAX_LAT) begin
            tick();
            lat++;
        end
        check({tag, " update seen"}, 64'(update), 64'd1);
        if (check_lat) check({tag, " latency bound"}, 64'(lat <= MAX_LAT), 64'd1);
        tick();
        check({tag, " update one cycle"}, 64'(update), 64'd0);
        check({tag, " busy low"}, 64'(busy), 64'd0);
        check({tag, " update count"}, 64'(upd_cnt), 64'(u0 + 1));
        check_outputs(tag);
    endtask

    initial begin
        int u0;
        logic signed [W-1:0] r;
        model_reset();
        repeat (2) tick();

        check("reset num2", 64'(num2), 64'd0);
        check("reset num1", 64'(num1), 64'd0);
        check("reset num0", 64'(num0), 64'd0);
        check("reset neg", 64'(neg), 64'd0);
        check("reset update", 64'(update), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset overrun", 64'(overrun), 64'd0);
        reset_n = 1'b1;
        tick();

        // Half scale and full negative scale
        smp[0] = 16'sh4000;
        smp[1] = 16'sh8000;
        u0 = upd_cnt;
        run_strobes(WIN, 2, 0, 3);
        finish_window("fullscale", u0, 1'b1);
        check("fullscale ch0 -6.1 num1", 64'(num1[3:0]), 64'd6);
        check("fullscale ch0 -6.1 num0", 64'(num0[3:0]), 64'd1);
        check("fullscale ch0 neg", 64'(neg[0]), 64'd1);
        check("fullscale ch1 0.0", 64'({num2[7:4], num1[7:4], num0[7:4]}), 64'd0);
        check("fullscale ch1 neg", 64'(neg[1]), 64'd0);

        // Silence clamps; constant 1 is the smallest non-zero level
        smp[0] = '0;
        smp[1] = 16'sd1;
        u0 = upd_cnt;
        run_strobes(WIN, 2, 12, 3);
        finish_window("quiet", u0, 1'b1);
        check("quiet ch0 99.9", 64'({num2[3:0], num1[3:0], num0[3:0]}), 64'h999);
        check("quiet ch1 90.4", 64'({num2[7:4], num1[7:4], num0[7:4]}), 64'h904);
        check("quiet ch1 neg", 64'(neg[1]), 64'd1);

        for (int k = 0; k < 3; k++) begin
            u0 = upd_cnt;
            run_strobes(WIN, 0, $urandom_range(0, 15), 3);
            finish_window($sformatf("random%0d", k), u0, 1'b1);
        end

        // clear mid-window, with a coincident strobe that must be ignored
        for (int c = 0; c < CH; c++) smp[c] = 16'sh4000;
        u0 = upd_cnt;
        run_strobes(WIN, CH, 0, 3);
        finish_window("preclear", u0, 1'b1);
        u0 = upd_cnt;
        run_strobes(20, 0, 2, 3);
        repeat (3) tick();
        in_data  = {CH{16'h7fff}};
        in_valid = 1'b1;
        clear    = 1'b1;
        tick();
        in_valid = 1'b0;
        clear    = 1'b0;
        for (int c = 0; c < CH; c++) sum_m[c] = 0;
        cnt_m = 0;
        for (int c = 0; c < CH; c++) begin
            r      = W'($urandom);
            smp[c] = r >>> (c + 1);
        end
        run_strobes(WIN - 20, CH, 0, 3);
        repeat (MAX_LAT + 5) tick();
        check("clear no stale update", 64'(upd_cnt), 64'(u0));
        check("clear idle", 64'(busy), 64'd0);
        run_strobes(20, CH, 0, 3);
        finish_window("postclear", u0, 1'b1);

        // Reset during BCD of channel 0 (silence makes each channel's BCD long)
        for (int c = 0; c < CH; c++) smp[c] = '0;
        u0 = upd_cnt;
        run_strobes(WIN, CH, 0, 3);
        repeat (8) tick();
        check("midbcd busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        tick();
        check("midbcd rst num2", 64'(num2), 64'd0);
        check("midbcd rst num1", 64'(num1), 64'd0);
        check("midbcd rst num0", 64'(num0), 64'd0);
        check("midbcd rst neg", 64'(neg), 64'd0);
        check("midbcd rst busy", 64'(busy), 64'd0);
        check("midbcd rst update", 64'(update), 64'd0);
        reset_n = 1'b1;
        model_reset();
        repeat (MAX_LAT) tick();
        check("midbcd no update", 64'(upd_cnt), 64'(u0));
        run_strobes(WIN, 0, 3, 3);
        finish_window("afterreset", u0, 1'b1);

        // Back-to-back windows: second one ends while the first is still converting
        check("overrun clear", 64'(overrun), 64'd0);
        u0 = upd_cnt;
        run_strobes(WIN, 0, 14, 0);
        discard = 1'b1;
        run_strobes(WIN, 0, 0, 0);
        discard = 1'b0;
        check("overrun busy at end", 64'(busy), 64'd1);
        check("overrun set", 64'(overrun), 64'd1);
        finish_window("overrun first", u0, 1'b0);
        repeat (MAX_LAT) tick();
        check("overrun snapshot dropped", 64'(upd_cnt), 64'(u0 + 1));
        u0 = upd_cnt;
        run_strobes(WIN, 0, 2, 3);
        finish_window("overrun next", u0, 1'b1);
        check("overrun sticky", 64'(overrun), 64'd1);

`ifdef LEVEL_PEAK_HOLD_EN
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        model_reset();
        tick();
        for (int c = 0; c < CH; c++) smp[c] = 16'sh4000;
        u0 = upd_cnt;
        run_strobes(WIN, CH, 0, 3);
        finish_window("hold load", u0, 1'b1);
        for (int c = 0; c < CH; c++) smp[c] = '0;
        for (int k = 0; k < 4; k++) begin
            u0 = upd_cnt;
            run_strobes(WIN, CH, 0, 3);
            finish_window($sformatf("hold%0d", k), u0, 1'b1);
            check($sformatf("hold%0d ch0 -6.1", k), 64'({num2[3:0], num1[3:0], num0[3:0]}),
                  64'h061);
        end
        u0 = upd_cnt;
        run_strobes(WIN, CH, 0, 3);
        finish_window("hold release", u0, 1'b1);
        check("hold release ch0 99.9", 64'({num2[3:0], num1[3:0], num0[3:0]}), 64'h999);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/level_meter_multi.md
Name: level_meter_multi

Overview:
- Multi-channel mean-square level meter. Measures each channel over a fixed power-of-two sample window and converts the result to dBFS in tenths of a dB.
- Produces three BCD digits plus a sign per channel, for the seven-segment display driver. Reads the `XX.X` format, clamped at -99.9.
- Sits on the 48 kHz audio path and taps signed PCM samples from the channel strip. The processing path is unchanged.
- Replaces the single-window, fixed-value meter with a real log conversion and a sequential BCD converter shared across channels.

Parameters:
- WIDTH, 16, sample width in bits, signed two's complement; must be 8..24.
- CHANNELS, 2, number of independent channels metered; must be 1..8.
- WINDOW_LOG2, 13, window length is 2^WINDOW_LOG2 valid samples; must be 6..16.
- HOLD_WINDOWS, 4, peak-hold release time in windows; used only with LEVEL_PEAK_HOLD_EN.

Ports:
- clk_48  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  sample strobe; one sample per channel per pulse.
- in_data  in  CHANNELS*WIDTH  channel c occupies `[c*WIDTH +: WIDTH]`, signed.
- clear  in  1  synchronous; abandons the current window.
- num2  out  CHANNELS*4  tens digit (BCD); channel c occupies `[c*4 +: 4]`.
- num1  out  CHANNELS*4  units digit (BCD).
- num0  out  CHANNELS*4  tenths digit (BCD).
- neg  out  CHANNELS  1 = value below 0.0 dBFS.
- update  out  1  one-cycle pulse when all channel digits have been refreshed.
- busy  out  1  converter active.
- overrun  out  1  sticky; a window end occurred while busy.

Behaviour:
- Interface: clock clk_48; reset reset_n, asynchronous, active-low.
- Reset: all accumulators, sample counter, snapshots and FSM are cleared. Outputs reset to: num2/num1/num0 = 0, neg = 0, update = 0, busy = 0, overrun = 0. FSM returns to IDLE. Reset mid-conversion aborts the conversion with no update.
- Accumulate: on each in_valid, acc[c] += in_data[c]^2.
  - Square is computed at 2*WIDTH bits; accumulator width is 2*WIDTH+WINDOW_LOG2, so it never wraps.
  - Counter is WINDOW_LOG2+1 bits.
- Window end: the in_valid that brings the count to 2^WINDOW_LOG2 is included in the window.
  - On that same edge, snapshot ms[c] = acc[c] >> WINDOW_LOG2 (2*WIDTH bits).
  - Accumulators and counter load 0.
  - FSM leaves IDLE on the next cycle.
- Busy at window end: if busy=1 at window end, the snapshot is discarded, accumulators still restart, and overrun is set (cleared only by reset).
- clear:
  - Zeroes accumulators and counter on the next edge.
  - Takes priority over a coincident window end, so no snapshot is taken.
  - A conversion already in progress completes normally.
  - in_valid while clear=1 is ignored.
- FSM: IDLE -> LOG -> SCALE -> BCD -> (next channel: LOG | last channel: DONE) -> IDLE. busy=1 in every state except IDLE.
- LOG (1 cycle):
  - p = position of MSB of ms.
  - f = the 4 bits below the MSB, zero-padded when p<4.
  - L = 16*p + f.
  - If ms = 0, flag zero.
- SCALE (1 cycle):
  - t = ((L - 32*(WIDTH-1)) * 1927) >>> 10, arithmetic shift (floor).
  - If zero, or t < -999, then t = -999.
  - neg = (t < 0); magnitude m = |t|. t > 0 is impossible; force 0 if it occurs.
- BCD (repeated subtraction, one subtraction per cycle):
  - Tens digit: while m >= 100, m -= 100 and digit increments.
  - Units digit: same with 10.
  - Tenths digit = remainder.
  - At most 30 cycles per channel.
- Register update: results for channel c are held internally. All channels' num2/num1/num0/neg registers load together in DONE.
  - update pulses in DONE for exactly one cycle; busy falls on the following cycle.
- Latency: window end to update is at most 34*CHANNELS+2 cycles.
  - Integration must ensure 2^WINDOW_LOG2 input strobes take longer than this; the defaults do.

Optional Feature:
- LEVEL_PEAK_HOLD_EN defined:
  - Each channel keeps held_t (signed) and a hold counter (clog2(HOLD_WINDOWS+1) bits).
  - In SCALE, if t >= held_t, or the hold counter has expired, then held_t = t and the counter reloads HOLD_WINDOWS. Otherwise the counter decrements and t = held_t.
  - Reset sets held_t = -999 and the counter to 0.
  - clear does not affect the hold.
- Undefined: no hold logic; the display tracks each window directly.
- Ports are identical in both builds.

Test Plan:
- Reset, then 8192 strobes of 16384 on ch0 and -32768 on ch1 -> one update pulse; ch0 num2/num1/num0 = 0/6/1 with neg=1 (-6.1); ch1 = 0/0/0 with neg=0.
- Zero input on ch0 and constant 1 on ch1 for one window -> ch0 = 9/9/9 with neg=1 (clamp); ch1 = 9/0/4 with neg=1 (-90.4).
- Window of 16384 followed by assert clear at sample 5000 of the next window -> no update at what would have been that window's end; the next update comes 8192 strobes after clear, with values matching the post-clear input.
- WINDOW_LOG2=6, CHANNELS=8, in_valid every cycle -> second window end arrives while busy=1; overrun=1 and stays set; the first update still shows the correct values.
- Assert reset_n low for one cycle mid-BCD -> all outputs 0, busy=0, no update pulse; the next full window converts correctly.
- With LEVEL_PEAK_HOLD_EN, HOLD_WINDOWS=4: one window at 16384, then zeros -> ch0 shows -6.1 for 4 more windows, then 99.9 with neg=1.
